// File: rtl/contador_pkg.sv
// Shared encodings and the BCD step function for the millisecond stopwatch.
// The state codes are visible on the estado port.
package contador_pkg;

    localparam int DW   = 4;
    localparam int NDIG = 4;
    localparam logic [DW-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10
    } estado_t;

    // Four BCD digits, index 0 = units of ms.
    typedef logic [NDIG-1:0][DW-1:0] tiempo_t;

    // The >= comparison also pulls an out-of-range value back to 0.
    function automatic logic [DW-1:0] bcd_siguiente(input logic [DW-1:0] v, input logic inc);
        if (!inc)
            return v;
        return (v >= BCD_MAX) ? '0 : v + DW'(1);
    endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD decade counter (0..9) with synchronous clear and ripple carry.
// Latency: valor updates on the edge that samples inc; acarreo is combinational from inc.
// Backpressure: none, inc is honoured on every edge.
module digito_bcd
    import contador_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [DW-1:0] valor,
    output logic          acarreo
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valor <= '0;
        else if (clr)
            valor <= '0;
        else
            valor <= bcd_siguiente(valor, inc);
    end

    assign acarreo = inc && (valor == BCD_MAX);

endmodule

// File: rtl/contador_ms_bcd.sv
// Millisecond stopwatch: prescaler to a 1 ms tick feeding four cascaded BCD digits.
// Latency: digits, tick_ms and desborde change on the same edge, DIV cycles after entering CONTANDO.
// Backpressure: none; commands are level-sampled. Lap capture is built with CONTADOR_CAPTURA_EN.
module contador_ms_bcd
    import contador_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inicio,
    input  logic          pausa,
    input  logic          borrar,
`ifdef CONTADOR_CAPTURA_EN
    input  logic          captura,
    output logic [DW-1:0] cap0,
    output logic [DW-1:0] cap1,
    output logic [DW-1:0] cap2,
    output logic [DW-1:0] cap3,
`endif
    output logic [DW-1:0] digito0,
    output logic [DW-1:0] digito1,
    output logic [DW-1:0] digito2,
    output logic [DW-1:0] digito3,
    output logic          tick_ms,
    output logic          desborde,
    output logic [1:0]    estado
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_FIN = PW'(DIV - 1);

    estado_t       est_q;
    estado_t       est_d;
    logic [PW-1:0] pre_q;
    logic          avanza;
    logic          fin_ms;
    logic [DW-1:0] valor [NDIG];
    logic [NDIG:0] carry;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            est_q <= REPOSO;
        else
            est_q <= est_d;
    end

    // Only the highest-priority asserted command is considered each edge.
    always_comb begin
        est_d = est_q;
        if (borrar)
            est_d = REPOSO;
        else if (pausa) begin
            if (est_q == CONTANDO)
                est_d = PAUSADO;
        end else if (inicio) begin
            if (est_q != CONTANDO)
                est_d = CONTANDO;
        end
    end

    // ---------------- prescaler ----------------
    // A pausa on the terminal count blocks the increment and keeps DIV-1,
    // so the millisecond completes on the first counting edge after resume.
    assign avanza = (est_q == CONTANDO) && !pausa && !borrar;
    assign fin_ms = avanza && (pre_q == PRE_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_q <= '0;
        else if (borrar || est_q == REPOSO || fin_ms)
            pre_q <= '0;
        else if (avanza)
            pre_q <= pre_q + PW'(1);
    end

    // ---------------- BCD digit chain ----------------
    assign carry[0] = fin_ms;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        digito_bcd u_dig (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (borrar),
            .inc     (carry[i]),
            .valor   (valor[i]),
            .acarreo (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_ms  <= 1'b0;
            desborde <= 1'b0;
        end else if (borrar) begin
            tick_ms  <= 1'b0;
            desborde <= 1'b0;
        end else begin
            tick_ms  <= fin_ms;
            desborde <= carry[NDIG];
        end
    end

    assign digito0 = valor[0];
    assign digito1 = valor[1];
    assign digito2 = valor[2];
    assign digito3 = valor[3];
    assign estado  = est_q;

`ifdef CONTADOR_CAPTURA_EN
    // ---------------- lap capture ----------------
    // Latch the post-update digits so an increment on the capture edge is included.
    tiempo_t sig;
    tiempo_t cap_q;

    always_comb begin
        sig = '0;
        for (int i = 0; i < NDIG; i++)
            sig[i] = bcd_siguiente(valor[i], carry[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cap_q <= '0;
        else if (borrar)
            cap_q <= '0;
        else if (captura && est_q != REPOSO)
            cap_q <= sig;
    end

    assign cap0 = cap_q[0];
    assign cap1 = cap_q[1];
    assign cap2 = cap_q[2];
    assign cap3 = cap_q[3];
`endif

endmodule

// File: tb/tb_contador_ms_bcd.sv
// Bench for contador_ms_bcd: directed scenarios plus random commands checked each cycle
// against an elapsed-cycle model (ms = counting cycles / DIV).
module tb_contador_ms_bcd;

    localparam int CLK_HZ  = 3;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       inicio = 1'b0;
    logic       pausa  = 1'b0;
    logic       borrar = 1'b0;
    logic [3:0] digito0, digito1, digito2, digito3;
    logic       tick_ms, desborde;
    logic [1:0] estado;
`ifdef CONTADOR_CAPTURA_EN
    logic       captura = 1'b0;
    logic [3:0] cap0, cap1, cap2, cap3;
`endif

    contador_ms_bcd #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .pausa    (pausa),
        .borrar   (borrar),
`ifdef CONTADOR_CAPTURA_EN
        .captura  (captura),
        .cap0     (cap0),
        .cap1     (cap1),
        .cap2     (cap2),
        .cap3     (cap3),
`endif
        .digito0  (digito0),
        .digito1  (digito1),
        .digito2  (digito2),
        .digito3  (digito3),
        .tick_ms  (tick_ms),
        .desborde (desborde),
        .estado   (estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int n_tick = 0;
    int n_wrap = 0;

    // Model: mode 0 idle, 1 counting, 2 paused; run = cycles spent counting.
    int     mode   = 0;
    longint run    = 0;
    bit     m_tick = 1'b0;
    bit     m_wrap = 1'b0;
    longint m_cap  = 0;

    function automatic logic [15:0] bcd_of(input longint ms);
        longint m;
        m = ms % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_digits();
        return 32'({digito3, digito2, digito1, digito0});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; run = 0; m_tick = 0; m_wrap = 0; m_cap = 0;
        end else if (borrar) begin
            mode = 0; run = 0; m_tick = 0; m_wrap = 0; m_cap = 0;
        end else begin
            m_tick = 0;
            m_wrap = 0;
            if (mode == 1 && !pausa) begin
                run++;
                if (run % DIV == 0) begin
                    m_tick = 1;
                    m_wrap = ((run / DIV) % 10000 == 0);
                end
            end
`ifdef CONTADOR_CAPTURA_EN
            if (captura && mode != 0)
                m_cap = (run / DIV) % 10000;
`endif
            if (pausa) begin
                if (mode == 1) mode = 2;
            end else if (inicio) begin
                mode = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("digits", dut_digits(), 32'(bcd_of(run / DIV)));
            check("tick_ms", 32'(tick_ms), 32'(m_tick));
            check("desborde", 32'(desborde), 32'(m_wrap));
            check("estado", 32'(estado), 32'(mode));
`ifdef CONTADOR_CAPTURA_EN
            check("cap", 32'({cap3, cap2, cap1, cap0}), 32'(bcd_of(m_cap)));
`endif
            n_tick += int'(tick_ms);
            n_wrap += int'(desborde);
        end
    end

    initial begin
        // Reset state, before any clock edge.
        #3;
        check("rst_digits", dut_digits(), 32'h0);
        check("rst_tick", 32'(tick_ms), 32'h0);
        check("rst_desborde", 32'(desborde), 32'h0);
        check("rst_estado", 32'(estado), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;

        // Basic count: first increment DIV cycles after entering CONTANDO.
        n_tick = 0;
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        check("enter_estado", 32'(estado), 32'h1);
        cyc(DIV - 1);
        check("first_inc_early", dut_digits(), 32'h0000);
        cyc(1);
        check("first_inc", dut_digits(), 32'h0001);
        check("first_tick", 32'(tick_ms), 32'h1);
        cyc(25 * DIV - DIV);
        check("basic_digits", dut_digits(), 32'h0025);
        check("basic_ticks", 32'(n_tick), 32'd25);
        check("basic_estado", 32'(estado), 32'h1);

        // Pause mid-millisecond (prescaler = 1), held high, then resume.
        cyc(1);
        pausa = 1'b1; cyc(37); pausa = 1'b0;
        check("paused_digits", dut_digits(), 32'h0025);
        check("paused_estado", 32'(estado), 32'h2);
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        check("resume_estado", 32'(estado), 32'h1);
        cyc(DIV - 2);
        check("resume_no_tick", 32'(tick_ms), 32'h0);
        cyc(1);
        check("resume_tick", 32'(tick_ms), 32'h1);
        check("resume_digits", dut_digits(), 32'h0026);

        // Pause on the terminal prescaler value: pause wins.
        cyc(DIV - 1);
        pausa = 1'b1; cyc(1);
        check("edge_pause_digits", dut_digits(), 32'h0026);
        check("edge_pause_tick", 32'(tick_ms), 32'h0);
        pausa = 1'b0; cyc(5);
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        check("edge_resume_digits", dut_digits(), 32'h0026);
        cyc(1);
        check("edge_first_digits", dut_digits(), 32'h0027);
        check("edge_first_tick", 32'(tick_ms), 32'h1);

        // Priority with a tick due on the same edge.
        cyc(15 * DIV + DIV - 1);
        check("prio_before", dut_digits(), 32'h0042);
        borrar = 1'b1; pausa = 1'b1; inicio = 1'b1; cyc(1);
        borrar = 1'b0; pausa = 1'b0; inicio = 1'b0;
        check("prio_digits", dut_digits(), 32'h0000);
        check("prio_estado", 32'(estado), 32'h0);
        check("prio_tick", 32'(tick_ms), 32'h0);
        cyc(DIV + 1);
        check("idle_stays", dut_digits(), 32'h0000);

`ifdef CONTADOR_CAPTURA_EN
        // Capture on an incrementing edge.
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        cyc(13 * DIV - 1);
        captura = 1'b1; cyc(1); captura = 1'b0;
        check("cap_value", 32'({cap3, cap2, cap1, cap0}), 32'h0013);
        check("cap_digits", dut_digits(), 32'h0013);
        cyc(10);
        check("cap_hold", 32'({cap3, cap2, cap1, cap0}), 32'h0013);
        check("cap_run_on", dut_digits(), 32'h0016);
        borrar = 1'b1; cyc(1); borrar = 1'b0;
        check("cap_clear", 32'({cap3, cap2, cap1, cap0}), 32'h0000);
`endif

        // Wrap 9999 -> 0000.
        borrar = 1'b1; cyc(1); borrar = 1'b0;
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        cyc(9998 * DIV);
        check("pre_wrap", dut_digits(), 32'h9998);
        n_wrap = 0;
        cyc(DIV);
        check("max_val", dut_digits(), 32'h9999);
        check("no_early_wrap", 32'(desborde), 32'h0);
        cyc(DIV);
        check("wrap_digits", dut_digits(), 32'h0000);
        check("wrap_desborde", 32'(desborde), 32'h1);
        check("wrap_tick", 32'(tick_ms), 32'h1);
        cyc(20 - 2 * DIV);
        check("wrap_pulses", 32'(n_wrap), 32'd1);
        check("after_wrap", dut_digits(), 32'h0000 + 32'(bcd_of((20 - 2 * DIV) / DIV)));

        // Random commands against the model.
        borrar = 1'b1; cyc(1); borrar = 1'b0;
        repeat (3000) begin
            borrar = ($urandom_range(0, 99) < 2);
            pausa  = ($urandom_range(0, 99) < 8);
            inicio = ($urandom_range(0, 99) < 12);
`ifdef CONTADOR_CAPTURA_EN
            captura = ($urandom_range(0, 99) < 10);
`endif
            cyc(1);
        end
        borrar = 1'b0; pausa = 1'b0; inicio = 1'b0;
`ifdef CONTADOR_CAPTURA_EN
        captura = 1'b0;
`endif

        // Asynchronous reset mid-count.
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        cyc(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digits", dut_digits(), 32'h0);
        check("arst_tick", 32'(tick_ms), 32'h0);
        check("arst_desborde", 32'(desborde), 32'h0);
        check("arst_estado", 32'(estado), 32'h0);
`ifdef CONTADOR_CAPTURA_EN
        check("arst_cap", 32'({cap3, cap2, cap1, cap0}), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        inicio = 1'b1; cyc(1); inicio = 1'b0;
        cyc(DIV);
        check("post_rst_count", dut_digits(), 32'h0001);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
